// File: rtl/axi3_slave_mem.sv
// AXI3 slave memory: independent single-outstanding write and read engines over a word array,
// with FIXED/INCR/WRAP address generation, byte strobes, narrow beats and per-beat error responses.
module axi3_slave_mem #(
  parameter int unsigned          ID_W      = 4,
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic                aclk,
  input  logic                areset,
  // write address
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  // write data
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  // write response
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  // read address
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [3:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  // read data
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned TOP_W  = OFF_W + IDX_W;

  localparam logic [1:0] RespOkay   = 2'd0;
  localparam logic [1:0] RespSlvErr = 2'd2;
  localparam logic [1:0] RespDecErr = 2'd3;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] BurstRsvd  = 2'b11;

  typedef enum logic [1:0] {StWIdle, StWData, StWResp} wstate_e;
  typedef enum logic {StRIdle, StRData} rstate_e;

  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  // BASE_ADDR is aligned to the memory size, so range is a compare of the upper address bits.
  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:TOP_W] == BASE_ADDR[ADDR_W-1:TOP_W];
  endfunction

  function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a);
    return a[TOP_W-1:OFF_W];
  endfunction

  function automatic logic f_burst_err(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [3:0] len);
    logic wrap_bad;
    wrap_bad = (burst == BurstWrap) &&
               !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
    return (32'(size) > OFF_W) || (burst == BurstRsvd) || wrap_bad;
  endfunction

  function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst,
                                                    input logic [3:0] len);
    logic [ADDR_W-1:0] nb, inc, span_m1, res;
    nb      = ADDR_W'(1) << size;
    inc     = (a & ~(nb - ADDR_W'(1))) + nb;
    span_m1 = nb * (ADDR_W'(len) + ADDR_W'(1)) - ADDR_W'(1);
    case (burst)
      BurstFixed: res = a;
      BurstWrap:  res = (a & ~span_m1) | (inc & span_m1);
      default:    res = inc;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] f_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // ---------------------------------------------------------------- write path
  wstate_e             r_wstate;
  logic                r_awready, r_wready, r_bvalid;
  logic [ID_W-1:0]     r_bid, r_w_id;
  logic [1:0]          r_bresp, r_w_err;
  logic [ADDR_W-1:0]   r_w_addr;
  logic [3:0]          r_w_len, r_w_cnt;
  logic [2:0]          r_w_size;
  logic [1:0]          r_w_burst;
  logic                r_w_bad;

  logic                w_aw_bad, w_w_fire, w_w_final, w_w_inr, w_mem_we;
  logic [1:0]          w_w_beat_resp, w_w_worst;
  logic                w_unused_wid;

  assign w_unused_wid  = ^wid;
  assign w_aw_bad      = f_burst_err(awsize, awburst, awlen);
  assign w_w_fire      = (r_wstate == StWData) && wvalid && r_wready;
  assign w_w_final     = (r_w_cnt == r_w_len);
  assign w_w_inr       = f_in_range(r_w_addr);
  assign w_w_beat_resp = r_w_bad ? RespSlvErr : (w_w_inr ? RespOkay : RespDecErr);
  assign w_w_worst     = f_worst(f_worst(r_w_err, w_w_beat_resp),
                                 (wlast != w_w_final) ? RespSlvErr : RespOkay);
  assign w_mem_we      = w_w_fire && !areset && !r_w_bad && w_w_inr;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wstate  <= StWIdle;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= RespOkay;
      r_w_id    <= '0;
      r_w_err   <= RespOkay;
      r_w_addr  <= '0;
      r_w_len   <= '0;
      r_w_cnt   <= '0;
      r_w_size  <= '0;
      r_w_burst <= '0;
      r_w_bad   <= 1'b0;
    end else begin
      unique case (r_wstate)
        StWIdle: begin
          if (awvalid && r_awready) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_w_id    <= awid;
            r_w_addr  <= awaddr;
            r_w_len   <= awlen;
            r_w_size  <= awsize;
            r_w_burst <= awburst;
            r_w_cnt   <= '0;
            r_w_bad   <= w_aw_bad;
            r_w_err   <= w_aw_bad ? RespSlvErr : RespOkay;
            r_wstate  <= StWData;
          end else begin
            r_awready <= 1'b1;
          end
        end
        StWData: begin
          if (w_w_fire) begin
            // Burst length comes from awlen; wlast only contributes to the response.
            if (w_w_final) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_w_worst;
              r_bid    <= r_w_id;
              r_wstate <= StWResp;
            end else begin
              r_w_err  <= w_w_worst;
              r_w_cnt  <= r_w_cnt + 4'd1;
              r_w_addr <= f_next_addr(r_w_addr, r_w_size, r_w_burst, r_w_len);
            end
          end
        end
        StWResp: begin
          if (bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= StWIdle;
          end
        end
        default: r_wstate <= StWIdle;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (w_mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) r_mem[f_idx(r_w_addr)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- read path
  rstate_e             r_rstate;
  logic                r_arready, r_rvalid, r_rlast;
  logic [ID_W-1:0]     r_rid;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rresp;
  logic [ADDR_W-1:0]   r_r_addr;
  logic [3:0]          r_r_len, r_r_cnt;
  logic [2:0]          r_r_size;
  logic [1:0]          r_r_burst;
  logic                r_r_bad;

  logic                w_ar_bad, w_r_sel_bad;
  logic [ADDR_W-1:0]   w_r_sel_addr;
  logic [1:0]          w_r_resp;
  logic [DATA_W-1:0]   w_r_data;

  // In idle the beat being fetched is beat 0 of the incoming request; otherwise r_r_addr holds
  // the address of the next beat to present.
  assign w_ar_bad     = f_burst_err(arsize, arburst, arlen);
  assign w_r_sel_addr = (r_rstate == StRIdle) ? araddr : r_r_addr;
  assign w_r_sel_bad  = (r_rstate == StRIdle) ? w_ar_bad : r_r_bad;
  assign w_r_resp     = w_r_sel_bad ? RespSlvErr :
                        (f_in_range(w_r_sel_addr) ? RespOkay : RespDecErr);
  assign w_r_data     = (w_r_resp == RespOkay) ? r_mem[f_idx(w_r_sel_addr)] : '0;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rstate  <= StRIdle;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= RespOkay;
      r_r_addr  <= '0;
      r_r_len   <= '0;
      r_r_cnt   <= '0;
      r_r_size  <= '0;
      r_r_burst <= '0;
      r_r_bad   <= 1'b0;
    end else begin
      unique case (r_rstate)
        StRIdle: begin
          if (arvalid && r_arready) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rid     <= arid;
            r_rdata   <= w_r_data;
            r_rresp   <= w_r_resp;
            r_rlast   <= (arlen == 4'd0);
            r_r_len   <= arlen;
            r_r_size  <= arsize;
            r_r_burst <= arburst;
            r_r_bad   <= w_ar_bad;
            r_r_cnt   <= '0;
            r_r_addr  <= f_next_addr(araddr, arsize, arburst, arlen);
            r_rstate  <= StRData;
          end else begin
            r_arready <= 1'b1;
          end
        end
        StRData: begin
          if (rready) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= StRIdle;
            end else begin
              r_rdata  <= w_r_data;
              r_rresp  <= w_r_resp;
              r_rlast  <= ((r_r_cnt + 4'd1) == r_r_len);
              r_r_cnt  <= r_r_cnt + 4'd1;
              r_r_addr <= f_next_addr(r_r_addr, r_r_size, r_r_burst, r_r_len);
            end
          end
        end
        default: r_rstate <= StRIdle;
      endcase
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bid     = r_bid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rlast   = r_rlast;

endmodule

// File: tb/tb_axi3_slave_mem.sv
// Directed bench for axi3_slave_mem: writes build a known memory image, then a table of read
// bursts is checked beat by beat; hand sequences cover backpressure and mid-burst reset.
module tb_axi3_slave_mem;
  localparam int unsigned ID_W = 4, ADDR_W = 32, DATA_W = 32, MEM_WORDS = 1024;

  logic aclk = 1'b0;
  logic areset;
  logic [ID_W-1:0] awid, wid, bid, arid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [3:0] awlen, arlen, wstrb;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [DATA_W-1:0] wdata, rdata;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;

  axi3_slave_mem #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .BASE_ADDR('0)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id, b_id;
  logic [1:0]  b_resp;

  typedef struct {
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [3:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0][1:0]  resp;
    logic [3:0][31:0] data;
  } rd_vec_t;

  rd_vec_t vt [10];

  function automatic rd_vec_t mkv(input logic [3:0] id, input logic [31:0] addr,
                                  input logic [3:0] len, input logic [2:0] size,
                                  input logic [1:0] burst,
                                  input logic [1:0] r0, input logic [1:0] r1,
                                  input logic [1:0] r2, input logic [1:0] r3,
                                  input logic [31:0] d0, input logic [31:0] d1,
                                  input logic [31:0] d2, input logic [31:0] d3);
    rd_vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.resp[0] = r0; v.resp[1] = r1; v.resp[2] = r2; v.resp[3] = r3;
    v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timed_out(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({awready, wready, bvalid, bid, bresp, arready, rid, rdata, rresp, rlast, rvalid});
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    if (!awready) timed_out("aw_handshake");
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic do_w(input int len, input int last_at);
    for (int i = 0; i <= len; i++) begin
      int n = 0;
      wvalid = 1'b1; wdata = wr_data[i]; wstrb = wr_strb[i]; wlast = (i == last_at);
      while (!wready && n < 50) begin @(negedge aclk); n++; end
      if (!wready) timed_out("w_beat");
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic do_b();
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    if (!bvalid) timed_out("b_response");
    b_resp = bresp; b_id = bid;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    do_aw(id, addr, len, size, burst);
    do_w(int'(len), int'(len));
    do_b();
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    if (!arready) timed_out("ar_handshake");
    @(negedge aclk);
    arvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    do_ar(id, addr, len, size, burst);
    rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      int n = 0;
      while (!rvalid && n < 50) begin @(negedge aclk); n++; end
      if (!rvalid) timed_out("r_beat");
      rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast; rd_id = rid;
      @(negedge aclk);
    end
    rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [37:0] snap;
    logic        stalled;
    int          got;

    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    repeat (3) @(negedge aclk);
    chk("reset_outputs", all_outs(), 64'h0);
    areset = 1'b0;
    @(negedge aclk);
    chk("idle_ready", 64'({awready, arready}), 64'h3);

    // INCR burst at 0x10
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(32'hA0 + i); wr_strb[i] = 4'hF; end
    axi_write(4'd5, 32'h10, 4'd3, 3'd2, 2'b01);
    chk("incr_bresp", 64'(b_resp), 64'd0);
    chk("incr_bid", 64'(b_id), 64'd5);

    // image for WRAP reads at 0x30..0x3C
    for (int i = 0; i < 4; i++) wr_data[i] = 32'(32'hC0 + i);
    axi_write(4'd2, 32'h30, 4'd3, 3'd2, 2'b01);
    chk("load_bresp", 64'(b_resp), 64'd0);

    // narrow byte writes into word 0
    wr_data[0] = 32'hFFFF_FFFF; wr_strb[0] = 4'hF;
    axi_write(4'd1, 32'h0, 4'd0, 3'd2, 2'b01);
    wr_data[0] = 32'h0000_0011; wr_strb[0] = 4'h1;
    wr_data[1] = 32'h0000_2200; wr_strb[1] = 4'h2;
    wr_data[2] = 32'h0033_0000; wr_strb[2] = 4'h4;
    wr_data[3] = 32'h4400_0000; wr_strb[3] = 4'h8;
    axi_write(4'd1, 32'h0, 4'd3, 3'd0, 2'b01);
    chk("narrow_bresp", 64'(b_resp), 64'd0);

    // straddles the top of memory by two beats
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(32'hD0 + i); wr_strb[i] = 4'hF; end
    axi_write(4'd6, 32'hFF8, 4'd3, 3'd2, 2'b01);
    chk("straddle_bresp", 64'(b_resp), 64'd3);

    // wlast early on beat 1 of a 4-beat burst: burst still runs 4 beats
    do_aw(4'd3, 32'h100, 4'd3, 3'd2, 2'b01);
    do_w(3, 1);
    chk("wlast_err_wready_low", 64'(wready), 64'd0);
    chk("wlast_err_bvalid", 64'(bvalid), 64'd1);
    do_b();
    chk("wlast_err_bresp", 64'(b_resp), 64'd2);

    // B channel backpressure
    wr_data[0] = 32'h0000_5A5A; wr_strb[0] = 4'hF;
    do_aw(4'd6, 32'h40, 4'd0, 3'd2, 2'b01);
    do_w(0, 0);
    for (int k = 0; k < 5; k++) begin
      chk("bstall_bvalid", 64'(bvalid), 64'd1);
      chk("bstall_bid_bresp", 64'({bid, bresp}), 64'({4'd6, 2'd0}));
      chk("bstall_awready", 64'(awready), 64'd0);
      @(negedge aclk);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("bdone_bvalid", 64'(bvalid), 64'd0);
    chk("bdone_awready", 64'(awready), 64'd1);

    // R channel backpressure, rready alternating
    do_ar(4'd5, 32'h10, 4'd3, 3'd2, 2'b01);
    got = 0; stalled = 1'b0; snap = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      rready = (cyc % 2 == 0);
      if (rvalid) begin
        if (stalled) chk("rstall_stable", 64'({rdata, rresp, rlast, rid}), 64'(snap));
        if (rready) begin
          chk("rbp_data", 64'(rdata), 64'(32'hA0 + got));
          chk("rbp_last", 64'(rlast), 64'(got == 3));
          got++;
          stalled = 1'b0;
        end else begin
          snap = {rdata, rresp, rlast, rid};
          stalled = 1'b1;
        end
      end
      @(negedge aclk);
    end
    rready = 1'b0;
    if (got < 4) timed_out("rbp_beats");
    chk("rdone_idle", 64'({rvalid, arready}), 64'h1);

    // reset during beat 2 of an 8-beat write
    for (int i = 0; i < 8; i++) begin wr_data[i] = 32'(32'hE0 + i); wr_strb[i] = 4'hF; end
    do_aw(4'd7, 32'h200, 4'd7, 3'd2, 2'b01);
    do_w(1, 7);
    wvalid = 1'b1; wdata = wr_data[2]; wstrb = 4'hF; areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0; wvalid = 1'b0;
    chk("midreset_outputs", all_outs(), 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk("midreset_no_b", 64'(bvalid), 64'd0);
    end
    axi_write(4'd7, 32'h200, 4'd7, 3'd2, 2'b01);
    chk("postreset_bresp", 64'(b_resp), 64'd0);
    chk("postreset_bid", 64'(b_id), 64'd7);

    // read table: id, addr, len, size, burst, per-beat resp, per-beat data
    vt[0] = mkv(4'd5, 32'h10, 4'd3, 3'd2, 2'b01, 2'd0, 2'd0, 2'd0, 2'd0,
                32'hA0, 32'hA1, 32'hA2, 32'hA3);
    vt[1] = mkv(4'd9, 32'h38, 4'd3, 3'd2, 2'b10, 2'd0, 2'd0, 2'd0, 2'd0,
                32'hC2, 32'hC3, 32'hC0, 32'hC1);
    vt[2] = mkv(4'd9, 32'h38, 4'd2, 3'd2, 2'b10, 2'd2, 2'd2, 2'd2, 2'd0,
                32'h0, 32'h0, 32'h0, 32'h0);
    vt[3] = mkv(4'd1, 32'h0, 4'd0, 3'd0, 2'b01, 2'd0, 2'd0, 2'd0, 2'd0,
                32'h4433_2211, 32'h0, 32'h0, 32'h0);
    vt[4] = mkv(4'd2, 32'h14, 4'd1, 3'd2, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0,
                32'hA1, 32'hA1, 32'h0, 32'h0);
    vt[5] = mkv(4'd3, 32'h10, 4'd0, 3'd3, 2'b01, 2'd2, 2'd0, 2'd0, 2'd0,
                32'h0, 32'h0, 32'h0, 32'h0);
    vt[6] = mkv(4'd4, 32'h10, 4'd1, 3'd2, 2'b11, 2'd2, 2'd2, 2'd0, 2'd0,
                32'h0, 32'h0, 32'h0, 32'h0);
    vt[7] = mkv(4'd6, 32'hFF8, 4'd3, 3'd2, 2'b01, 2'd0, 2'd0, 2'd3, 2'd3,
                32'hD0, 32'hD1, 32'h0, 32'h0);
    vt[8] = mkv(4'd0, 32'h40, 4'd0, 3'd2, 2'b01, 2'd0, 2'd0, 2'd0, 2'd0,
                32'h5A5A, 32'h0, 32'h0, 32'h0);
    vt[9] = mkv(4'd7, 32'h208, 4'd0, 3'd2, 2'b01, 2'd0, 2'd0, 2'd0, 2'd0,
                32'hE2, 32'h0, 32'h0, 32'h0);

    for (int v = 0; v < 10; v++) begin
      axi_read(vt[v].id, vt[v].addr, vt[v].len, vt[v].size, vt[v].burst);
      chk($sformatf("rd%0d_rid", v), 64'(rd_id), 64'(vt[v].id));
      for (int b = 0; b <= int'(vt[v].len); b++) begin
        chk($sformatf("rd%0d_data%0d", v, b), 64'(rd_data[b]), 64'(vt[v].data[b]));
        chk($sformatf("rd%0d_resp%0d", v, b), 64'(rd_resp[b]), 64'(vt[v].resp[b]));
        chk($sformatf("rd%0d_last%0d", v, b), 64'(rd_last[b]), 64'(b == int'(vt[v].len)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
